// File: rtl/lpm_pkg.sv
// Shared types and write-path helpers for the longest-prefix-match TCAM.
package lpm_pkg;

    localparam int MAXW = 128;
    localparam int CNTW = $clog2(MAXW + 1);

    typedef logic [MAXW-1:0] wide_t;

    typedef enum logic [2:0] {
        WR_IDLE,
        WR_FLUSH,
        WR_LOAD,
        WR_CLEAR,
        WR_REJECT
    } wr_op_e;

    function automatic logic [CNTW-1:0] popcount(input wide_t v);
        logic [CNTW-1:0] n;
        n = '0;
        for (int i = 0; i < MAXW; i++) begin
            n = n + CNTW'(v[i]);
        end
        return n;
    endfunction

    // Expects the mask left-justified in MAXW bits: valid iff the inverted mask is 0..01..1.
    function automatic logic mask_is_contiguous(input wide_t m);
        wide_t inv;
        inv = ~m;
        return (inv & (inv + wide_t'(1))) == '0;
    endfunction

endpackage

// File: rtl/lpm_prio_reduce.sv
// Combinational binary tree picking the longest valid length; ties resolve to the lower index.
module lpm_prio_reduce #(
    parameter int DEPTH = 16,
    parameter int LENW  = 6,
    parameter int IDXW  = 4
) (
    input  logic [DEPTH-1:0] valid_i,
    input  logic [LENW-1:0]  len_i [DEPTH],
    output logic             hit_o,
    output logic [LENW-1:0]  len_o,
    output logic [IDXW-1:0]  idx_o
);

    localparam int LEAVES = 1 << IDXW;
    localparam int NODES  = 2 * LEAVES - 1;

    logic            node_v   [NODES];
    logic [LENW-1:0] node_len [NODES];
    logic [IDXW-1:0] node_idx [NODES];

    // Heap layout: leaves sit at LEAVES-1+k in index order, so a left child always
    // covers lower entry indices than its right sibling.
    always_comb begin
        // NOTE: every node gets a default first so no path through the loops can infer a latch.
        for (int k = 0; k < NODES; k++) begin
            node_v[k]   = 1'b0;
            node_len[k] = '0;
            node_idx[k] = '0;
        end
        for (int k = 0; k < DEPTH; k++) begin
            node_v[LEAVES-1+k]   = valid_i[k];
            node_len[LEAVES-1+k] = len_i[k];
            node_idx[LEAVES-1+k] = IDXW'(k);
        end
        for (int k = LEAVES - 2; k >= 0; k--) begin
            if (node_v[2*k+1] && (!node_v[2*k+2] || node_len[2*k+1] >= node_len[2*k+2])) begin
                node_v[k]   = node_v[2*k+1];
                node_len[k] = node_len[2*k+1];
                node_idx[k] = node_idx[2*k+1];
            end else begin
                node_v[k]   = node_v[2*k+2];
                node_len[k] = node_len[2*k+2];
                node_idx[k] = node_idx[2*k+2];
            end
        end
    end

    assign hit_o = node_v[0];
    assign len_o = node_len[0];
    assign idx_o = node_idx[0];

endmodule

// File: rtl/lpm_tcam_pipe.sv
// Two-stage longest-prefix-match TCAM: flop table, S1 parallel compare, S2 priority reduce.
module lpm_tcam_pipe #(
    parameter  int WIDTH      = 32,
    parameter  int DEPTH      = 16,
    parameter  int IFW        = 4,
    parameter  int DEFAULT_IF = 0,
    localparam int IDXW       = $clog2(DEPTH),
    localparam int LENW       = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             lk_valid,
    input  logic [WIDTH-1:0] lk_addr,
    output logic             res_valid,
    output logic             res_hit,
    output logic [WIDTH-1:0] res_prefix,
    output logic [LENW-1:0]  res_len,
    output logic [IFW-1:0]   res_if,
    output logic [IDXW-1:0]  res_index,
    input  logic             wr_en,
    input  logic [IDXW-1:0]  wr_index,
    input  logic [WIDTH-1:0] wr_prefix,
    input  logic [WIDTH-1:0] wr_mask,
    input  logic [IFW-1:0]   wr_if,
    input  logic             wr_set,
    input  logic             flush,
    output logic             wr_err
);

    import lpm_pkg::*;

    logic [DEPTH-1:0] valid_q, valid_d;
    logic [WIDTH-1:0] prefix_q [DEPTH];
    logic [WIDTH-1:0] mask_q   [DEPTH];
    logic [LENW-1:0]  len_q    [DEPTH];
    logic [IFW-1:0]   if_q     [DEPTH];

    wr_op_e          wr_op;
    wide_t           mask_wide;
    logic            idx_bad;
    logic [LENW-1:0] wr_len;
    logic            wr_err_q;

    assign mask_wide = wide_t'(wr_mask) << (MAXW - WIDTH);
    assign idx_bad   = (int'(wr_index) >= DEPTH);
    assign wr_len    = LENW'(popcount(wide_t'(wr_mask)));

    always_comb begin
        wr_op = WR_IDLE;
        if (flush) begin
            wr_op = WR_FLUSH;
        end else if (wr_en) begin
            if (idx_bad || (wr_set && !mask_is_contiguous(mask_wide))) begin
                wr_op = WR_REJECT;
            end else if (wr_set) begin
                wr_op = WR_LOAD;
            end else begin
                wr_op = WR_CLEAR;
            end
        end
    end

    always_comb begin
        valid_d = valid_q;
        case (wr_op)
            WR_FLUSH: valid_d = '0;
            WR_LOAD:  valid_d[wr_index] = 1'b1;
            WR_CLEAR: valid_d[wr_index] = 1'b0;
            default:  valid_d = valid_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            valid_q  <= '0;
            wr_err_q <= 1'b0;
        end else begin
            valid_q  <= valid_d;
            wr_err_q <= (wr_op == WR_REJECT);
        end
    end

    // NOTE: entry payload is not reset; the valid bits alone decide whether a field is ever used.
    always_ff @(posedge clk) begin
        if (wr_op == WR_LOAD) begin
            prefix_q[wr_index] <= wr_prefix & wr_mask;
            mask_q[wr_index]   <= wr_mask;
            len_q[wr_index]    <= wr_len;
            if_q[wr_index]     <= wr_if;
        end
    end

    logic [DEPTH-1:0] match_d;
    logic             s1_valid_q;
    logic [DEPTH-1:0] s1_match_q;
    logic [LENW-1:0]  s1_len_q  [DEPTH];
    logic [IFW-1:0]   s1_if_q   [DEPTH];
    logic [WIDTH-1:0] s1_addr_q;

    always_comb begin
        match_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            match_d[i] = valid_q[i] && ((lk_addr & mask_q[i]) == prefix_q[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
        end else begin
            s1_valid_q <= lk_valid;
        end
    end

    // Interfaces are snapshotted here so a write landing while the lookup sits in S2
    // cannot leak into its result.
    always_ff @(posedge clk) begin
        s1_match_q <= match_d;
        s1_len_q   <= len_q;
        s1_if_q    <= if_q;
        s1_addr_q  <= lk_addr;
    end

    logic            win_hit;
    logic [LENW-1:0] win_len;
    logic [IDXW-1:0] win_idx;

    lpm_prio_reduce #(
        .DEPTH (DEPTH),
        .LENW  (LENW),
        .IDXW  (IDXW)
    ) u_reduce (
        .valid_i (s1_match_q),
        .len_i   (s1_len_q),
        .hit_o   (win_hit),
        .len_o   (win_len),
        .idx_o   (win_idx)
    );

    logic             res_valid_q,  res_valid_d;
    logic             res_hit_q,    res_hit_d;
    logic [WIDTH-1:0] res_prefix_q, res_prefix_d;
    logic [LENW-1:0]  res_len_q,    res_len_d;
    logic [IFW-1:0]   res_if_q,     res_if_d;
    logic [IDXW-1:0]  res_index_q,  res_index_d;

    // The matched prefix equals the address truncated to the winning length.
    always_comb begin
        res_valid_d  = s1_valid_q;
        res_hit_d    = res_hit_q;
        res_prefix_d = res_prefix_q;
        res_len_d    = res_len_q;
        res_if_d     = res_if_q;
        res_index_d  = res_index_q;
        if (s1_valid_q) begin
            res_hit_d = win_hit;
            if (win_hit) begin
                res_prefix_d = s1_addr_q & ~({WIDTH{1'b1}} >> win_len);
                res_len_d    = win_len;
                res_if_d     = s1_if_q[win_idx];
                res_index_d  = win_idx;
            end else begin
                res_prefix_d = '0;
                res_len_d    = '0;
                res_if_d     = IFW'(DEFAULT_IF);
                res_index_d  = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_valid_q  <= 1'b0;
            res_hit_q    <= 1'b0;
            res_prefix_q <= '0;
            res_len_q    <= '0;
            res_if_q     <= IFW'(DEFAULT_IF);
            res_index_q  <= '0;
        end else begin
            res_valid_q  <= res_valid_d;
            res_hit_q    <= res_hit_d;
            res_prefix_q <= res_prefix_d;
            res_len_q    <= res_len_d;
            res_if_q     <= res_if_d;
            res_index_q  <= res_index_d;
        end
    end

    assign res_valid  = res_valid_q;
    assign res_hit    = res_hit_q;
    assign res_prefix = res_prefix_q;
    assign res_len    = res_len_q;
    assign res_if     = res_if_q;
    assign res_index  = res_index_q;
    assign wr_err     = wr_err_q;

endmodule
